sum_sequencer: RTL and testbench

//  Controller that sequences the 12-bit adder submodule from decoded keypad entries.

---
 rtl/sum_seq_pkg.sv | 33 +++
 rtl/digit_accumulator.sv | 66 ++++++
 rtl/sum_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_sum_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/sum_seq_pkg.sv
// Shared types and constants for the keypad-driven adder sequencer.
package sum_seq_pkg;

  localparam int W_OP       = 12;
  localparam int W_SUM      = 14;
  localparam int MAX_DIGITS = 3;
  localparam int TIMEOUT    = 16;
  localparam int W_CNT      = 2;
  localparam int W_TMO      = 5;

  localparam logic [3:0] KEY_NEXT = 4'hA;
  localparam logic [3:0] KEY_EQ   = 4'hB;
  localparam logic [3:0] KEY_CLR  = 4'hC;

  localparam logic [1:0] SEL_OP1 = 2'd0;
  localparam logic [1:0] SEL_OP2 = 2'd1;
  localparam logic [1:0] SEL_SUM = 2'd2;
  localparam logic [1:0] SEL_ERR = 2'd3;

  typedef enum logic [2:0] {
    S_OP1  = 3'd0,
    S_OP2  = 3'd1,
    S_REQ  = 3'd2,
    S_WAIT = 3'd3,
    S_SHOW = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  function automatic logic is_digit(input logic [3:0] key);
    return (key <= 4'd9);
  endfunction

endpackage

// File: rtl/digit_accumulator.sv
// Holds one decimal operand and the number of digits entered into it.
// Digits beyond MAX_DIGITS are dropped, so the value never exceeds 999.
module digit_accumulator
  import sum_seq_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_clear,
  input  logic            i_load,
  input  logic            i_push,
  input  logic [3:0]      i_digit,
  output logic [W_OP-1:0] o_value,
  output logic [W_OP-1:0] o_value_next,
  output logic [W_CNT-1:0] o_count
);

  logic [W_OP-1:0]  r_value;
  logic [W_CNT-1:0] r_count;
  logic [W_OP-1:0]  w_value_next;
  logic [W_CNT-1:0] w_count_next;
  logic [W_OP-1:0]  w_times10;
  logic [W_OP-1:0]  w_digit_ext;

  assign w_times10   = (r_value << 3) + (r_value << 1);
  assign w_digit_ext = {{(W_OP - 4){1'b0}}, i_digit};

  // Next operand value: clear beats load beats push; push honours the digit limit.
  always_comb begin
    w_value_next = r_value;
    w_count_next = r_count;
    if (i_clear) begin
      w_value_next = {W_OP{1'b0}};
      w_count_next = {W_CNT{1'b0}};
    end else if (i_load) begin
      w_value_next = w_digit_ext;
      w_count_next = W_CNT'(1);
    end else if (i_push) begin
      if (r_count < W_CNT'(MAX_DIGITS)) begin
        w_value_next = w_times10 + w_digit_ext;
        w_count_next = r_count + W_CNT'(1);
      end else begin
        w_value_next = r_value;
        w_count_next = r_count;
      end
    end else begin
      w_value_next = r_value;
      w_count_next = r_count;
    end
  end

  // Operand and digit-count registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_value <= {W_OP{1'b0}};
      r_count <= {W_CNT{1'b0}};
    end else begin
      r_value <= w_value_next;
      r_count <= w_count_next;
    end
  end

  assign o_value      = r_value;
  assign o_value_next = w_value_next;
  assign o_count      = r_count;

endmodule

// File: rtl/sum_sequencer.sv
// Keypad-to-adder sequencer: builds two decimal operands, requests one add,
// latches the adder result and selects what the display shows.
// Optional feature macro: ADDER_TIMEOUT_EN (gives up on a silent adder and
// reports an error after TIMEOUT cycles in S_WAIT).
module sum_sequencer
  import sum_seq_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_key_valid,
  input  logic [3:0]       i_key_code,
  output logic [W_OP-1:0]  o_number1,
  output logic [W_OP-1:0]  o_number2,
  output logic             o_enable,
  input  logic [W_SUM-1:0] i_sum_result,
  input  logic             i_sum_state,
  output logic [W_SUM-1:0] o_display_value,
  output logic [1:0]       o_display_sel,
  output logic             o_busy,
  output logic             o_error
);

  state_t           r_state;
  state_t           w_state_next;
  logic [W_SUM-1:0] r_sum;
  logic [W_SUM-1:0] w_sum_next;
  logic             r_enable;
  logic             r_busy;
  logic [1:0]       r_display_sel;
  logic [W_SUM-1:0] r_display_value;

  logic w_digit_key;
  logic w_next_key;
  logic w_eq_key;
  logic w_clr_key;

  logic w_op1_clear;
  logic w_op1_load;
  logic w_op1_push;
  logic w_op2_clear;
  logic w_op2_push;

  logic [W_OP-1:0]  w_op1_value;
  logic [W_OP-1:0]  w_op1_value_next;
  logic [W_CNT-1:0] w_op1_count;
  logic [W_OP-1:0]  w_op2_value;
  logic [W_OP-1:0]  w_op2_value_next;
  logic [W_CNT-1:0] w_op2_count;

`ifdef ADDER_TIMEOUT_EN
  logic [W_TMO-1:0] r_wait_cnt;
  logic             r_error;
`endif

  assign w_digit_key = i_key_valid && is_digit(i_key_code);
  assign w_next_key  = i_key_valid && (i_key_code == KEY_NEXT);
  assign w_eq_key    = i_key_valid && (i_key_code == KEY_EQ);
  assign w_clr_key   = i_key_valid && (i_key_code == KEY_CLR);

  digit_accumulator u_op1 (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_clear      (w_op1_clear),
    .i_load       (w_op1_load),
    .i_push       (w_op1_push),
    .i_digit      (i_key_code),
    .o_value      (w_op1_value),
    .o_value_next (w_op1_value_next),
    .o_count      (w_op1_count)
  );

  digit_accumulator u_op2 (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_clear      (w_op2_clear),
    .i_load       (1'b0),
    .i_push       (w_op2_push),
    .i_digit      (i_key_code),
    .o_value      (w_op2_value),
    .o_value_next (w_op2_value_next),
    .o_count      (w_op2_count)
  );

  // Key/adder event decode into next state and operand strobes; clear wins over everything.
  always_comb begin
    w_state_next = r_state;
    w_op1_clear  = 1'b0;
    w_op1_load   = 1'b0;
    w_op1_push   = 1'b0;
    w_op2_clear  = 1'b0;
    w_op2_push   = 1'b0;
    if (w_clr_key) begin
      w_state_next = S_OP1;
      w_op1_clear  = 1'b1;
      w_op2_clear  = 1'b1;
    end else begin
      case (r_state)
        S_OP1: begin
          if (w_digit_key) begin
            w_op1_push = 1'b1;
          end else if (w_next_key && (w_op1_count != {W_CNT{1'b0}})) begin
            w_state_next = S_OP2;
          end else begin
            w_state_next = S_OP1;
          end
        end
        S_OP2: begin
          if (w_digit_key) begin
            w_op2_push = 1'b1;
          end else if (w_eq_key && (w_op2_count != {W_CNT{1'b0}})) begin
            w_state_next = S_REQ;
          end else begin
            w_state_next = S_OP2;
          end
        end
        S_REQ: begin
          w_state_next = S_WAIT;
        end
        S_WAIT: begin
          if (i_sum_state) begin
            w_state_next = S_SHOW;
`ifdef ADDER_TIMEOUT_EN
          end else if (r_wait_cnt == W_TMO'(TIMEOUT - 1)) begin
            w_state_next = S_ERR;
`endif
          end else begin
            w_state_next = S_WAIT;
          end
        end
        S_SHOW, S_ERR: begin
          if (w_digit_key) begin
            w_state_next = S_OP1;
            w_op1_load   = 1'b1;
            w_op2_clear  = 1'b1;
          end else begin
            w_state_next = r_state;
          end
        end
        default: begin
          w_state_next = S_OP1;
          w_op1_clear  = 1'b1;
          w_op2_clear  = 1'b1;
        end
      endcase
    end
  end

  // Result latch: captured only on the S_WAIT cycle where the adder reports valid.
  always_comb begin
    w_sum_next = r_sum;
    if (w_clr_key) begin
      w_sum_next = {W_SUM{1'b0}};
    end else if ((r_state == S_WAIT) && i_sum_state) begin
      w_sum_next = i_sum_result;
    end else begin
      w_sum_next = r_sum;
    end
  end

  // FSM state plus outputs registered from the next state so they line up with it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state         <= S_OP1;
      r_sum           <= {W_SUM{1'b0}};
      r_enable        <= 1'b0;
      r_busy          <= 1'b0;
      r_display_sel   <= SEL_OP1;
      r_display_value <= {W_SUM{1'b0}};
`ifdef ADDER_TIMEOUT_EN
      r_wait_cnt      <= {W_TMO{1'b0}};
      r_error         <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_next;
      r_sum    <= w_sum_next;
      r_enable <= (w_state_next == S_REQ);
      r_busy   <= (w_state_next == S_REQ) || (w_state_next == S_WAIT);
`ifdef ADDER_TIMEOUT_EN
      r_error  <= (w_state_next == S_ERR);
      if ((r_state == S_WAIT) && (w_state_next == S_WAIT)) begin
        r_wait_cnt <= r_wait_cnt + W_TMO'(1);
      end else begin
        r_wait_cnt <= {W_TMO{1'b0}};
      end
`endif
      case (w_state_next)
        S_OP1: begin
          r_display_sel   <= SEL_OP1;
          r_display_value <= {{(W_SUM - W_OP){1'b0}}, w_op1_value_next};
        end
        S_OP2, S_REQ, S_WAIT: begin
          r_display_sel   <= SEL_OP2;
          r_display_value <= {{(W_SUM - W_OP){1'b0}}, w_op2_value_next};
        end
        S_SHOW: begin
          r_display_sel   <= SEL_SUM;
          r_display_value <= w_sum_next;
        end
        S_ERR: begin
          r_display_sel   <= SEL_ERR;
          r_display_value <= {W_SUM{1'b0}};
        end
        default: begin
          r_display_sel   <= SEL_OP1;
          r_display_value <= {W_SUM{1'b0}};
        end
      endcase
    end
  end

  assign o_number1       = w_op1_value;
  assign o_number2       = w_op2_value;
  assign o_enable        = r_enable;
  assign o_busy          = r_busy;
  assign o_display_sel   = r_display_sel;
  assign o_display_value = r_display_value;
`ifdef ADDER_TIMEOUT_EN
  assign o_error         = r_error;
`else
  assign o_error         = 1'b0;
`endif

endmodule

// File: tb/tb_sum_sequencer.sv
// Self-checking bench for sum_sequencer: directed scenarios followed by
// random keypad/adder traffic, all compared cycle by cycle against a
// behavioural calculator model.
module tb_sum_sequencer;

  logic        clk;
  logic        reset;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [11:0] number1;
  logic [11:0] number2;
  logic        enable;
  logic [13:0] sum_result;
  logic        sum_state;
  logic [13:0] display_value;
  logic [1:0]  display_sel;
  logic        busy;
  logic        error;

  sum_sequencer dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_key_valid     (key_valid),
    .i_key_code      (key_code),
    .o_number1       (number1),
    .o_number2       (number2),
    .o_enable        (enable),
    .i_sum_result    (sum_result),
    .i_sum_state     (sum_state),
    .o_display_value (display_value),
    .o_display_sel   (display_sel),
    .o_busy          (busy),
    .o_error         (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Calculator model: phases 0=op1 1=op2 2=request 3=wait 4=show 5=error
  int m_phase, m_op1, m_op2, m_n1, m_n2, m_sum, m_wait;

  // Adder emulation
  int          adder_cnt = 0;
  logic [13:0] adder_val;
  bit          force_en = 1'b0;
  logic [13:0] force_val;
  int          force_dly = 0;
  bit          adder_mute = 1'b0;
  bit          noise_en = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic rst, input logic kv, input logic [3:0] kc,
                            input logic ss, input logic [13:0] sr);
    int k;
    k = int'(kc);
    if (rst) begin
      m_phase = 0; m_op1 = 0; m_op2 = 0; m_n1 = 0; m_n2 = 0; m_sum = 0; m_wait = 0;
    end else if (kv && k == 12) begin
      m_phase = 0; m_op1 = 0; m_op2 = 0; m_n1 = 0; m_n2 = 0; m_sum = 0;
    end else begin
      case (m_phase)
        0: if (kv && k < 10) begin
             if (m_n1 < 3) begin m_op1 = m_op1 * 10 + k; m_n1++; end
           end else if (kv && k == 10 && m_n1 > 0) m_phase = 1;
        1: if (kv && k < 10) begin
             if (m_n2 < 3) begin m_op2 = m_op2 * 10 + k; m_n2++; end
           end else if (kv && k == 11 && m_n2 > 0) m_phase = 2;
        2: begin m_phase = 3; m_wait = 0; end
        3: if (ss) begin
             m_sum = int'(sr); m_phase = 4;
           end else begin
             m_wait++;
`ifdef ADDER_TIMEOUT_EN
             if (m_wait == 16) m_phase = 5;
`endif
           end
        default: if (kv && k < 10) begin
             m_phase = 0; m_op1 = k; m_n1 = 1; m_op2 = 0; m_n2 = 0;
           end
      endcase
    end
  endtask

  task automatic step(input logic kv, input logic [3:0] kc);
    int exp_disp, exp_sel;
    key_valid = kv;
    key_code  = kc;
    if (adder_cnt == 1) begin
      sum_state = 1'b1; sum_result = adder_val;
    end else if (adder_cnt == 0 && noise_en && $urandom_range(0, 15) == 0) begin
      sum_state = 1'b1; sum_result = 14'($urandom_range(0, 1998));
    end else begin
      sum_state = 1'b0; sum_result = 14'($urandom);
    end
    if (adder_cnt != 0) adder_cnt--;
    @(posedge clk);
    model_edge(reset, kv, kc, sum_state, sum_result);
    #1;
    case (m_phase)
      0:       begin exp_disp = m_op1; exp_sel = 0; end
      1, 2, 3: begin exp_disp = m_op2; exp_sel = 1; end
      4:       begin exp_disp = m_sum; exp_sel = 2; end
      default: begin exp_disp = 0;     exp_sel = 3; end
    endcase
    check_eq("number1", 32'(number1), 32'(m_op1));
    check_eq("number2", 32'(number2), 32'(m_op2));
    check_eq("enable", 32'(enable), 32'(m_phase == 2));
    check_eq("busy", 32'(busy), 32'(m_phase == 2 || m_phase == 3));
    check_eq("error", 32'(error), 32'(m_phase == 5));
    check_eq("display_value", 32'(display_value), 32'(exp_disp));
    check_eq("display_sel", 32'(display_sel), 32'(exp_sel));
    if (enable && !adder_mute) begin
      adder_val = force_en ? force_val : 14'({2'b00, number1} + {2'b00, number2});
      adder_cnt = (force_dly != 0) ? force_dly : int'($urandom_range(2, 6));
    end
  endtask

  task automatic press(input logic [3:0] kc);
    step(1'b1, kc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0);
  endtask

  initial begin
    reset = 1'b1; key_valid = 1'b0; key_code = 4'h0; sum_state = 1'b0; sum_result = 14'd0;
    idle(2);
    check_eq("reset_display", 32'(display_value), 32'd0);
    check_eq("reset_enable", 32'(enable), 32'd0);
    reset = 1'b0;
    idle(1);

    // 367 + 980 with the adder reporting 1347
    force_en = 1'b1; force_val = 14'd1347; force_dly = 3;
    press(4'd3); press(4'd6); press(4'd7); press(4'hA);
    press(4'd9); press(4'd8); press(4'd0); press(4'hB);
    check_eq("t1_enable_after_b", 32'(enable), 32'd1);
    check_eq("t1_number1", 32'(number1), 32'd367);
    check_eq("t1_number2", 32'(number2), 32'd980);
    idle(1);
    check_eq("t1_enable_single", 32'(enable), 32'd0);
    idle(4);
    check_eq("t1_display", 32'(display_value), 32'd1347);
    check_eq("t1_sel", 32'(display_sel), 32'd2);
    force_en = 1'b0; force_dly = 0;

    // digit limit and ignored leading A
    press(4'hC);
    press(4'hA);
    check_eq("t2_a_ignored_sel", 32'(display_sel), 32'd0);
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    check_eq("t2_op1_limit", 32'(number1), 32'd123);
    press(4'hA);
    check_eq("t2_sel_op2", 32'(display_sel), 32'd1);

    // 999 + 999 then a digit restarts operand 1
    press(4'hC);
    press(4'd9); press(4'd9); press(4'd9); press(4'hA);
    press(4'd9); press(4'd9); press(4'd9); press(4'hB);
    idle(8);
    check_eq("t3_sum", 32'(display_value), 32'd1998);
    check_eq("t3_sel", 32'(display_sel), 32'd2);
    press(4'd5);
    check_eq("t3_op1", 32'(number1), 32'd5);
    check_eq("t3_op2", 32'(number2), 32'd0);
    check_eq("t3_sel_op1", 32'(display_sel), 32'd0);

    // clear while waiting; the late result must be ignored
    press(4'hC);
    force_dly = 8;
    press(4'd1); press(4'hA); press(4'd2); press(4'hB);
    idle(2);
    check_eq("t4_busy_wait", 32'(busy), 32'd1);
    press(4'hC);
    idle(10);
    check_eq("t4_display", 32'(display_value), 32'd0);
    check_eq("t4_sel", 32'(display_sel), 32'd0);
    check_eq("t4_number2", 32'(number2), 32'd0);
    force_dly = 0;

    // reset during the request cycle
    press(4'd1); press(4'hA); press(4'd2); press(4'hB);
    reset = 1'b1;
    idle(1);
    check_eq("t5_enable", 32'(enable), 32'd0);
    check_eq("t5_number1", 32'(number1), 32'd0);
    reset = 1'b0;
    idle(8);
    check_eq("t5_sel", 32'(display_sel), 32'd0);
    check_eq("t5_busy", 32'(busy), 32'd0);

`ifdef ADDER_TIMEOUT_EN
    // silent adder -> error after 16 wait cycles
    adder_mute = 1'b1;
    press(4'd4); press(4'hA); press(4'd5); press(4'hB);
    idle(16);
    check_eq("t6_no_error_yet", 32'(error), 32'd0);
    idle(1);
    check_eq("t6_error", 32'(error), 32'd1);
    check_eq("t6_sel", 32'(display_sel), 32'd3);
    press(4'hC);
    check_eq("t6_cleared", 32'(error), 32'd0);
    adder_mute = 1'b0;
`endif

    // random traffic
    noise_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      int r;
      if ($urandom_range(0, 1) == 0) begin
        step(1'b0, 4'($urandom));
      end else begin
        r = int'($urandom_range(0, 99));
        if (r < 55)      press(4'($urandom_range(0, 9)));
        else if (r < 70) press(4'hA);
        else if (r < 86) press(4'hB);
        else if (r < 89) press(4'hC);
        else             press(4'($urandom_range(13, 15)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
